// File: rtl/sfu_pkg.sv
// Shared types and constants for the SFU accumulation sequencer.
package sfu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        WAIT_RES,
        WRITE,
        FIN
    } sfu_state_e;

    localparam int KIJ  = 9;
    localparam int ONIJ = 16;
    localparam int COL  = 8;

    // Cycles spent in WAIT_RES before the watchdog gives up on the SFU.
    localparam int SFU_SEQ_TMO = 31;

endpackage

// File: rtl/sfu_seq_ctrl_if.sv
// Datapath-side handshake of the sequencer: ofifo pop, SFU strobes, output-memory write.
interface sfu_seq_ctrl_if #(
    parameter int col     = 8,
    parameter int addr_bw = 4
);
    logic [col-1:0]     ofifo_valid;
    logic               ofifo_rd;
    logic               acc_o;
    logic               clr_o;
    logic               sfu_valid_i;
    logic               out_wr;
    logic [addr_bw-1:0] out_addr;

    modport master (
        input  ofifo_valid,
        input  sfu_valid_i,
        output ofifo_rd,
        output acc_o,
        output clr_o,
        output out_wr,
        output out_addr
    );

    modport slave (
        output ofifo_valid,
        output sfu_valid_i,
        input  ofifo_rd,
        input  acc_o,
        input  clr_o,
        input  out_wr,
        input  out_addr
    );
endinterface

// File: rtl/sfu_seq_cnt.sv
// Terminal-count counter: clr wins over inc, and the count saturates at term instead of wrapping.
module sfu_seq_cnt #(
    parameter int width = 4,
    parameter int term  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] cnt,
    output logic             tc
);
    localparam logic [width-1:0] TERM_V = width'(term);

    assign tc = (cnt == TERM_V);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + width'(1);
        end
    end
endmodule

// File: rtl/sfu_seq_ctrl.sv
// Sequencer popping ofifo rows into the SFU kij times per position, then writing each result.
// Optional WAIT_RES watchdog with sticky err: define SFU_SEQ_TIMEOUT_EN.
module sfu_seq_ctrl
    import sfu_pkg::*;
#(
    parameter int col     = COL,
    parameter int kij     = KIJ,
    parameter int onij    = ONIJ,
    parameter int addr_bw = 4,
    parameter int kcnt_bw = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sfu_seq_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    sfu_state_e state, state_nx;

    logic [kcnt_bw-1:0] kcnt;
    logic [addr_bw-1:0] ocnt;
    logic               k_tc;
    logic               o_tc;
    logic               fire;
    logic               run_start;
    logic               timeout;

    // A pass needs the whole row, so every column's FIFO must be non-empty.
    assign fire      = (state == ACC) && (&bus.ofifo_valid);
    assign run_start = (state == IDLE) && start;

    sfu_seq_cnt #(.width(kcnt_bw), .term(kij - 1)) u_kcnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fire),
        .clr   (run_start || (fire && k_tc)),
        .cnt   (kcnt),
        .tc    (k_tc)
    );

    sfu_seq_cnt #(.width(addr_bw), .term(onij - 1)) u_ocnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state == WRITE),
        .clr   (run_start),
        .cnt   (ocnt),
        .tc    (o_tc)
    );

`ifdef SFU_SEQ_TIMEOUT_EN
    logic [4:0] wdog;
    logic       err_q;

    assign timeout = (state == WAIT_RES) && !bus.sfu_valid_i && (wdog == 5'(SFU_SEQ_TMO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog <= (state == WAIT_RES && !timeout) ? wdog + 5'd1 : 5'd0;
            if (run_start) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bus.ofifo_rd = 1'b0;
        bus.acc_o    = 1'b0;
        bus.clr_o    = 1'b0;
        bus.out_wr   = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ACC;
            end
            ACC: begin
                if (fire) begin
                    bus.ofifo_rd = 1'b1;
                    bus.acc_o    = 1'b1;
                    bus.clr_o    = (kcnt == '0);
                    if (k_tc) state_nx = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.sfu_valid_i) begin
                    state_nx = WRITE;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            WRITE: begin
                bus.out_wr = 1'b1;
                state_nx   = o_tc ? FIN : ACC;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.out_addr = ocnt;
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Self-checking bench for sfu_seq_ctrl: vector table of run shapes plus reset-abort and watchdog sequences.
module tb_sfu_seq_ctrl;
    localparam int COL_T  = 8;
    localparam int KIJ_T  = 9;
    localparam int ONIJ_T = 2;
    localparam int ADDR_T = 4;
    localparam int KCNT_T = 4;

    typedef struct {
        int holdAt;
        int holdLen;
        int sfuDelay;
        int spurAt;
        int restartAt;
        int expDone;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic err;

    sfu_seq_ctrl_if #(.col(COL_T), .addr_bw(ADDR_T)) bus ();

    sfu_seq_ctrl #(
        .col     (COL_T),
        .kij     (KIJ_T),
        .onij    (ONIJ_T),
        .addr_bw (ADDR_T),
        .kcnt_bw (KCNT_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errCount   = 0;

    vec_t cfg;
    vec_t vecs[5];
    int runSeq       = 0;
    int seenSeq      = 0;
    int cyc          = 0;
    int startCyc     = -100000;
    int finalPassCyc = -100000;
    int passTotal    = 0;
    int writeTotal   = 0;
    int doneTotal    = 0;
    int doneCyc      = 0;
    int clrLog[$];
    int expAddr[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    // Loads a run shape and pushes the expected write addresses onto the scoreboard.
    task automatic applyStimulus(input vec_t v);
        cfg        = v;
        passTotal  = 0;
        writeTotal = 0;
        doneTotal  = 0;
        clrLog.delete();
        expAddr.delete();
        for (int a = 0; a < ONIJ_T; a++) expAddr.push_back(a);
        runSeq++;
        @(negedge clk); #1;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (doneTotal == 0 && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) begin @(negedge clk); #1; end
        checkOutput("done_count", doneTotal, 1);
    endtask

    task automatic checkRun(input vec_t v, input int idx);
        checkOutput($sformatf("v%0d_passes", idx), passTotal, KIJ_T * ONIJ_T);
        checkOutput($sformatf("v%0d_clr_count", idx), clrLog.size(), ONIJ_T);
        for (int p = 0; p < ONIJ_T; p++) begin
            if (p < clrLog.size()) checkOutput($sformatf("v%0d_clr_pos%0d", idx, p), clrLog[p], p * KIJ_T + 1);
        end
        checkOutput($sformatf("v%0d_done_cycle", idx), doneCyc - startCyc, v.expDone);
        checkOutput($sformatf("v%0d_writes", idx), writeTotal, ONIJ_T);
        checkOutput($sformatf("v%0d_sb_left", idx), expAddr.size(), 0);
        checkOutput($sformatf("v%0d_busy_end", idx), int'(busy), 0);
        checkOutput($sformatf("v%0d_err", idx), int'(err), 0);
    endtask

    task automatic waitRel(input int target);
        int n = 0;
        while ((cyc - startCyc) < target && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    // Drives inputs just after each rising edge and monitors outputs on the falling edge.
    initial begin
        int rel;
        int expv;
        start           = 1'b0;
        bus.ofifo_valid = '1;
        bus.sfu_valid_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (runSeq != seenSeq) begin
                seenSeq  = runSeq;
                startCyc = cyc;
            end
            rel = cyc - startCyc;
            start = (rel == 0) || (cfg.restartAt > 0 && rel == cfg.restartAt);
            bus.ofifo_valid = (rel >= cfg.holdAt && rel < cfg.holdAt + cfg.holdLen) ? 8'hFE : 8'hFF;
            bus.sfu_valid_i = (cfg.sfuDelay >= 0 && cyc == finalPassCyc + 1 + cfg.sfuDelay) || (rel == cfg.spurAt);

            @(negedge clk);
            if (bus.ofifo_rd || bus.acc_o) checkOutput("rd_acc_pair", int'(bus.ofifo_rd), int'(bus.acc_o));
            if (bus.ofifo_valid != 8'hFF) checkOutput("stall_no_rd", int'(bus.ofifo_rd), 0);
            if (bus.clr_o) checkOutput("clr_needs_acc", int'(bus.acc_o), 1);
            if (bus.acc_o) begin
                passTotal++;
                if (passTotal % KIJ_T == 0) finalPassCyc = cyc;
                if (bus.clr_o) clrLog.push_back(passTotal);
            end
            if (bus.out_wr) begin
                writeTotal++;
                if (expAddr.size() == 0) begin
                    checkOutput("sb_pending", int'(expAddr.size() > 0), 1);
                end else begin
                    expv = expAddr.pop_front();
                    checkOutput("write_addr", int'(bus.out_addr), expv);
                    if (cfg.sfuDelay >= 0) checkOutput("write_cycle", cyc, finalPassCyc + cfg.sfuDelay + 2);
                end
            end
            if (done) begin
                doneTotal++;
                doneCyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: actual %0d cycles required completion", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        vec_t idleCfg;
        vec_t tmoCfg;
        idleCfg = '{-1, 0, -1, -1, 0, 0};
        tmoCfg  = '{-1, 0, -1, -1, 0, 0};
        vecs[0] = '{-1, 0,  0, -1, 0, 23};
        vecs[1] = '{ 4, 5,  0, -1, 0, 28};
        vecs[2] = '{-1, 0,  0, -1, 7, 23};
        vecs[3] = '{-1, 0, 10,  5, 0, 43};
        vecs[4] = '{14, 2,  1, -1, 0, 27};
        cfg   = idleCfg;
        reset = 1'b0;

        repeat (2) begin @(negedge clk); #1; end
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_out_wr", int'(bus.out_wr), 0);
        checkOutput("rst_ofifo_rd", int'(bus.ofifo_rd), 0);
        checkOutput("rst_out_addr", int'(bus.out_addr), 0);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            waitDone(300);
            checkRun(vecs[i], i);
        end

        // Abort mid-ACC once kcnt has reached 4, then confirm a fresh run starts from position 0.
        applyStimulus(vecs[0]);
        for (int n = 0; n < 50 && passTotal < 4; n++) begin @(negedge clk); #1; end
        checkOutput("abort_passes", passTotal, 4);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_acc", int'(bus.acc_o), 0);
        checkOutput("abort_rd", int'(bus.ofifo_rd), 0);
        @(negedge clk); #1;
        checkOutput("abort_out_addr", int'(bus.out_addr), 0);
        checkOutput("abort_out_wr", int'(bus.out_wr), 0);
        checkOutput("abort_done", int'(done), 0);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1;
        applyStimulus(vecs[0]);
        waitDone(300);
        checkRun(vecs[0], 5);

        // SFU never answers.
        applyStimulus(tmoCfg);
`ifdef SFU_SEQ_TIMEOUT_EN
        waitRel(41);
        checkOutput("tmo_busy_before", int'(busy), 1);
        checkOutput("tmo_err_before", int'(err), 0);
        @(negedge clk); #1;
        checkOutput("tmo_err", int'(err), 1);
        checkOutput("tmo_busy_after", int'(busy), 0);
        repeat (3) begin @(negedge clk); #1; end
        checkOutput("tmo_no_done", doneTotal, 0);
        checkOutput("tmo_no_write", writeTotal, 0);
        checkOutput("tmo_err_sticky", int'(err), 1);
`else
        waitRel(60);
        checkOutput("wait_busy", int'(busy), 1);
        checkOutput("wait_err", int'(err), 0);
        checkOutput("wait_no_done", doneTotal, 0);
        checkOutput("wait_no_write", writeTotal, 0);
        @(negedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk); #1;
`endif
        applyStimulus(vecs[0]);
        waitDone(300);
        checkRun(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
        $finish;
    end
endmodule
